// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter:
// parity codes, the one-hot FSM state type and a frame-length helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } tx_state_e;

  // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_len(input int data_bits, input int parity,
                                   input int stop_bits, input int baud_div);
    return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * baud_div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO with show-ahead read data, occupancy level and
// full/empty flags. Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: DATA_BITS data bits LSB first, optional
// odd/even parity, 1 or 2 stop bits, BAUD_DIV = CLK_FREQ/BAUD_RATE clocks
// per bit. Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front
// of the FSM; without it one character is accepted per frame in IDLE.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        ip_data,
  input  logic                        ip_valid,
  output logic                        ip_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BCW      = $clog2(BAUD_DIV);
  localparam int BTW      = $clog2(DATA_BITS + 1);
  localparam bit HAS_PAR  = (PARITY != PARITY_NONE);

  tx_state_e             state, state_nxt;
  logic [BCW-1:0]        baud_cnt;
  logic [BTW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic [DATA_BITS-1:0]  char_in;
  logic                  par_q;
  logic                  tick;
  logic                  start_frame;
  logic                  tx_d;

`ifdef UART_TX_FIFO_EN
  logic                  fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]  fifo_rdata;

  assign ip_ready    = !fifo_full && !rst;
  assign start_frame = (state == ST_IDLE) && !fifo_empty;
  assign char_in     = fifo_rdata;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ip_valid && ip_ready),
    .wdata (ip_data),
    .pop   (start_frame),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );
`else
  assign ip_ready    = (state == ST_IDLE) && !rst;
  assign start_frame = ip_valid && ip_ready;
  assign char_in     = ip_data;
  assign fifo_level  = '0;
`endif

  assign tick = (baud_cnt == BCW'(BAUD_DIV - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: every non-idle bit lasts one baud period; DATA and
  // STOP repeat until their bit counts are exhausted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_frame) state_nxt = ST_START;
      ST_START:  if (tick) state_nxt = ST_DATA;
      ST_DATA:   if (tick && bit_cnt == BTW'(DATA_BITS - 1))
                   state_nxt = HAS_PAR ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_nxt = ST_STOP;
      ST_STOP:   if (tick && bit_cnt == BTW'(STOP_BITS - 1)) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: line level for the coming cycle (registered below) and busy.
  // Within DATA the shift register advances on a tick, so the next bit is shreg[1].
  always_comb begin
    tx_d = 1'b1;
    case (state_nxt)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = (state == ST_DATA && tick) ? shreg[1] : shreg[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
    busy = (state != ST_IDLE);
  end

  // Datapath: registered tx, baud/bit counters, character latch and parity.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
    end else begin
      tx <= tx_d;
      if (state == ST_IDLE) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
        if (start_frame) begin
          shreg <= char_in;
          par_q <= (PARITY == PARITY_ODD) ? ~^char_in : ^char_in;
        end
      end else begin
        baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
        if (tick) begin
          bit_cnt <= (state_nxt != state) ? '0 : bit_cnt + 1'b1;
          if (state == ST_DATA) shreg <= shreg >> 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances (8N1, 8E2, 8O1, 5N1) at 16 clocks
// per bit, a vector table, random characters against a bit-level reference
// model, a mid-frame reset, and a FIFO burst when UART_TX_FIFO_EN is defined.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] vld_v = '0;
  logic [8:0] data_v [4];
  logic [3:0] tx_v, busy_v, rdy_v;
  logic [2:0] lvl0;
  logic [4:0] lvl1, lvl2, lvl3;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;

  int db_c  [4] = '{8, 8, 8, 5};
  int par_c [4] = '{0, 2, 1, 0};
  int sb_c  [4] = '{1, 2, 1, 1};

`ifdef UART_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .ip_data(data_v[0][7:0]), .ip_valid(vld_v[0]),
    .ip_ready(rdy_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .fifo_level(lvl0));
  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(16)) u1 (
    .clk(clk), .rst(rst), .ip_data(data_v[1][7:0]), .ip_valid(vld_v[1]),
    .ip_ready(rdy_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .fifo_level(lvl1));
  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .clk(clk), .rst(rst), .ip_data(data_v[2][7:0]), .ip_valid(vld_v[2]),
    .ip_ready(rdy_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .fifo_level(lvl2));
  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(5), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) u3 (
    .clk(clk), .rst(rst), .ip_data(data_v[3][4:0]), .ip_valid(vld_v[3]),
    .ip_ready(rdy_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .fifo_level(lvl3));

  typedef struct {
    int         cfg;
    logic [8:0] data;
    int         len;
    logic       pbit;   // line level in the bit slot right after the data bits
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int flen(input int idx);
    return (1 + db_c[idx] + (par_c[idx] != 0 ? 1 : 0) + sb_c[idx]) * 16;
  endfunction

  // Expected line level t cycles into a frame, from the bit-slot layout.
  function automatic logic exp_tx(input int idx, input logic [8:0] d, input int t);
    int b;
    int ones;
    b = t / 16;
    ones = 0;
    if (b == 0) return 1'b0;
    if (b <= db_c[idx]) return d[b-1];
    for (int i = 0; i < db_c[idx]; i++) ones += int'(d[i]);
    if (par_c[idx] != 0 && b == db_c[idx] + 1)
      return (par_c[idx] == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
    return 1'b1;
  endfunction

  // Send one character and compare every line cycle against the model.
  task automatic run_frame(input int idx, input logic [8:0] d,
                           output int blen, output logic pbit);
    int bad;
    bad = 0;
    @(negedge clk);
    chk("ready_idle", rdy_v[idx], 1);
    vld_v[idx]  = 1'b1;
    data_v[idx] = d;
    @(posedge clk);
    #1;
    vld_v[idx]  = 1'b0;
    data_v[idx] = 9'($urandom);
    blen = 0;
    pbit = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (tx_v[idx] !== 1'b1) bad++;
    end
    for (int t = 0; t < flen(idx); t++) begin
      @(negedge clk);
      if (t == 3) data_v[idx] = ~d;
      if (tx_v[idx] !== exp_tx(idx, d, t)) bad++;
      if (busy_v[idx] === 1'b1) blen++;
      if (t == (db_c[idx] + 1) * 16 + 8) pbit = tx_v[idx];
    end
    chk("frame_bit_errors", bad, 0);
    @(negedge clk);
    chk("idle_tx", tx_v[idx], 1);
    chk("idle_busy", busy_v[idx], 0);
  endtask

  initial begin
    vec_t vecs [4];
    int   blen;
    logic pb;
    logic [8:0] d;

    for (int i = 0; i < 4; i++) data_v[i] = '0;
    vecs[0] = '{cfg: 0, data: 9'h0A5, len: 160, pbit: 1'b1};
    vecs[1] = '{cfg: 1, data: 9'h0A5, len: 192, pbit: 1'b0};
    vecs[2] = '{cfg: 2, data: 9'h0A5, len: 176, pbit: 1'b1};
    vecs[3] = '{cfg: 3, data: 9'h0FF, len: 112, pbit: 1'b1};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx_v, 4'hF);
    chk("rst_busy", busy_v, 4'h0);
    chk("rst_ready", rdy_v, 4'h0);
    chk("rst_level", lvl0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", rdy_v, 4'hF);

    // Directed vectors
    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].cfg, vecs[v].data, blen, pb);
      chk("busy_len", blen, vecs[v].len);
      chk("bit_after_data", pb, vecs[v].pbit);
    end

    // Random characters on every configuration
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 3; r++) begin
        d = 9'($urandom);
        run_frame(i, d, blen, pb);
        chk("rand_busy_len", blen, flen(i));
      end

    // Reset in frame cycle 50, then a clean 0x3C frame
    @(negedge clk);
    vld_v[0]  = 1'b1;
    data_v[0] = 9'h0A5;
    @(posedge clk);
    #1 vld_v[0] = 1'b0;
    repeat (LAT + 50) @(negedge clk);
    chk("busy_midframe", busy_v[0], 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_tx", tx_v[0], 1);
    chk("midrst_busy", busy_v[0], 0);
    chk("midrst_ready", rdy_v[0], 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(0, 9'h03C, blen, pb);
    chk("post_rst_busy_len", blen, 160);

`ifdef UART_TX_FIFO_EN
    // Five back-to-back pushes into a 4-deep FIFO
    begin
      logic [7:0] q [$];
      int st [5];
      fork
        begin : prod
          int w;
          logic [7:0] b;
          for (int n = 0; n < 5; n++) begin
            b = 8'($urandom);
            @(negedge clk);
            chk("ready_vs_level", rdy_v[0], (lvl0 != 3'd4));
            vld_v[0]  = 1'b1;
            data_v[0] = {1'b0, b};
            w = 0;
            while (rdy_v[0] !== 1'b1 && w < 1000) begin
              @(negedge clk);
              w++;
            end
            if (w >= 1000) chk("push_timeout", w, 0);
            @(posedge clk);
            q.push_back(b);
          end
          @(negedge clk);
          chk("level_full", lvl0, 4);
          chk("ready_full", rdy_v[0], 0);
          vld_v[0] = 1'b0;
        end
        begin : cons
          int w;
          logic [159:0] s;
          logic [7:0] got, ex;
          for (int f = 0; f < 5; f++) begin
            w = 0;
            @(negedge clk);
            while (tx_v[0] !== 1'b0 && w < 400) begin
              @(negedge clk);
              w++;
            end
            if (w >= 400) chk("start_timeout", w, 0);
            st[f] = cyc;
            s[0] = tx_v[0];
            for (int t = 1; t < 160; t++) begin
              @(negedge clk);
              s[t] = tx_v[0];
            end
            for (int i = 0; i < 8; i++) got[i] = s[16 * (i + 1) + 8];
            ex = (q.size() > 0) ? q.pop_front() : 8'hxx;
            chk("fifo_byte", got, ex);
            chk("fifo_stop", s[152], 1);
            if (f > 0) chk("fifo_gap", st[f] - st[f-1], 161);
          end
        end
      join
      repeat (2) @(negedge clk);
      chk("fifo_drained", lvl0, 0);
    end
`else
    chk("no_fifo_level", {lvl0, lvl1, lvl2, lvl3}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
